id_queue_decode: RTL and testbench
==================================

Name: id_queue_decode

Overview:
- Next-generation RV32I decode stage: a QDEPTH-entry instruction queue from IF, decode of the queue head, regfile read, and N-source priority forwarding.
- Adds load-use hazard stalling, downstream backpressure, and flush; result is held in a registered ID/EX output.
- Sits between IF and EX in the 5-stage pipeline; the regfile read is combinational.

Parameters:
- XLEN, 32, datapath and PC width
- QDEPTH, 4, instruction queue entries; power of two, minimum 2
- NFWD, 2, forwarding sources; index 0 has highest priority (youngest stage)

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous reset, active-high
- if_valid_in  in  1  IF offers an instruction
- if_inst_in  in  32  instruction word
- if_pc_in  in  XLEN  instruction PC
- if_ready_out  out  1  queue not full
- flush_in  in  1  mispredict flush
- fwd_wreg_in  in  NFWD  source i writes a register
- fwd_waddr_in  in  5*NFWD  destination address of source i, at bits [5i+4:5i]
- fwd_wdata_in  in  XLEN*NFWD  data of source i
- ex_is_load_in  in  1  the instruction in EX is a load
- ex_load_rd_in  in  5  rd of that load
- rs1_read_out, rs2_read_out  out  1  regfile read enables (combinational)
- rs1_addr_out, rs2_addr_out  out  5  regfile read addresses (combinational)
- rs1_data_in, rs2_data_in  in  XLEN  regfile read data
- ex_ready_in  in  1  EX accepts the output register
- ex_valid_out  out  1  output register holds a valid instruction
- inst_type_out  out  `InstTypeBus  instruction type code from defines.v
- rs1_val_out, rs2_val_out  out  XLEN  operand values
- imm_out  out  XLEN  sign-extended immediate
- rd_we_out  out  1  instruction writes rd
- rd_addr_out  out  5  destination register
- pc_out  out  XLEN  PC of the instruction
- illegal_out  out  1  unrecognised opcode or funct3

Behaviour:
- Reset (async): queue empty with pointers at 0; every registered output is 0; inst_type_out is the NOP code.
- Queue:
  - Push when if_valid_in && if_ready_out.
  - if_ready_out = (count != QDEPTH); it does not depend on a pop in the same cycle.
  - Pointers wrap modulo QDEPTH.
  - Push and pop in the same cycle leave count unchanged.
- Decode (combinational on the queue head): covers OP-IMM, OP, BRANCH, LOAD, STORE, LUI, AUIPC, JAL, JALR.
  - Immediates use the I/S/B/U/J formats; shift immediates are zero-extended shamt.
  - funct7 bit 30 selects SUB/SRA/SRAI.
  - BLT decodes to BLT (not BNE).
  - rs1/rs2 read enables follow the format. When a read enable is 0, the corresponding address output is 0.
  - rd_we = 0 for BRANCH and STORE, and whenever rd = x0.
  - Illegal opcode/funct3: NOP type, rd_we = 0, illegal = 1.
- Operand selection, per rs with read enabled:
  - Use the lowest index i with fwd_wreg_in[i] && fwd_waddr_in[i] == rs && rs != 0.
  - Otherwise use the regfile data.
  - rs = x0 always yields 0.
  - A disabled rs yields 0; the immediate appears only on imm_out.
- Hazard: hz = queue non-empty && ex_is_load_in && ex_load_rd_in != 0 && (a read-enabled rs of the head == ex_load_rd_in).
- Issue condition: issue = !empty && !hz && !flush_in && (!ex_valid_out || ex_ready_in).
- Output register update:
  - issue: load decoded fields, ex_valid_out = 1, pop the queue. Latency is 1 cycle from head to output.
  - No issue and ex_ready_in: ex_valid_out = 0 (bubble). Data fields may hold stale values.
  - ex_valid_out && !ex_ready_in: hold all outputs unchanged.
- Flush (dominates everything):
  - Next edge: queue emptied, ex_valid_out = 0.
  - A push offered in the same cycle is dropped.
  - if_ready_out stays as computed from count.
- Mid-operation reset: asynchronously clears the state regardless of stall or flush.

Test Plan:
- Reset asserted mid-stream with 3 entries queued -> immediately ex_valid_out = 0, if_ready_out = 1; after release the first push of addi x1,x0,5 (0x00500093) gives, one cycle later, ex_valid_out = 1, type ADDI, imm_out = 5, rd_we_out = 1, rd_addr_out = 1.
- Forward priority: head add x3,x1,x2; fwd0 = (1, x1, 0xAAAA), fwd1 = (1, x1, 0xBBBB), rs2_data_in = 7 -> rs1_val_out = 0xAAAA, rs2_val_out = 7. With waddr = 0 on both sources, rs = x0 gives 0.
- Load-use: ex_is_load_in = 1, ex_load_rd_in = 5, head uses rs1 = x5 -> no pop, bubble (ex_valid_out = 0); next cycle with ex_is_load_in = 0 it issues.
- Backpressure/full: ex_ready_in = 0 and 4 pushes -> if_ready_out = 0 after the 4th; a 5th offer is not accepted; outputs hold. Raising ex_ready_in pops one per cycle, in order, with PCs 0x0, 0x4, 0x8, 0xC.
- Flush together with a push and 2 entries queued -> next cycle queue empty, ex_valid_out = 0; the pushed instruction never issues.
- Decode corners:
  - blt x1,x2,-4 -> type BLT, imm_out = 0xFFFFFFFC, rd_we_out = 0.
  - srai x1,x1,3 -> type SRAI, imm_out = 3.
  - opcode 0x7F -> illegal_out = 1, rd_we_out = 0.

Source files
------------

// File: rtl/id_queue_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// id_queue_decode : RV32I decode stage - IF instruction queue, head decode,
//                   prioritised forwarding, load-use stall, registered ID/EX.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module id_queue_decode #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int NFWD   = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 if_valid_in,
  input  logic [31:0]          if_inst_in,
  input  logic [XLEN-1:0]      if_pc_in,
  output logic                 if_ready_out,
  input  logic                 flush_in,
  input  logic [NFWD-1:0]      fwd_wreg_in,
  input  logic [5*NFWD-1:0]    fwd_waddr_in,
  input  logic [XLEN*NFWD-1:0] fwd_wdata_in,
  input  logic                 ex_is_load_in,
  input  logic [4:0]           ex_load_rd_in,
  output logic                 rs1_read_out,
  output logic                 rs2_read_out,
  output logic [4:0]           rs1_addr_out,
  output logic [4:0]           rs2_addr_out,
  input  logic [XLEN-1:0]      rs1_data_in,
  input  logic [XLEN-1:0]      rs2_data_in,
  input  logic                 ex_ready_in,
  output logic                 ex_valid_out,
  output logic [5:0]           inst_type_out,
  output logic [XLEN-1:0]      rs1_val_out,
  output logic [XLEN-1:0]      rs2_val_out,
  output logic [XLEN-1:0]      imm_out,
  output logic                 rd_we_out,
  output logic [4:0]           rd_addr_out,
  output logic [XLEN-1:0]      pc_out,
  output logic                 illegal_out
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full_count = CNT_W'(QDEPTH);

  localparam logic [5:0] c_ty_nop   = 6'd0;
  localparam logic [5:0] c_ty_lui   = 6'd1;
  localparam logic [5:0] c_ty_auipc = 6'd2;
  localparam logic [5:0] c_ty_jal   = 6'd3;
  localparam logic [5:0] c_ty_jalr  = 6'd4;
  localparam logic [5:0] c_ty_beq   = 6'd5;
  localparam logic [5:0] c_ty_bne   = 6'd6;
  localparam logic [5:0] c_ty_blt   = 6'd7;
  localparam logic [5:0] c_ty_bge   = 6'd8;
  localparam logic [5:0] c_ty_bltu  = 6'd9;
  localparam logic [5:0] c_ty_bgeu  = 6'd10;
  localparam logic [5:0] c_ty_lb    = 6'd11;
  localparam logic [5:0] c_ty_lh    = 6'd12;
  localparam logic [5:0] c_ty_lw    = 6'd13;
  localparam logic [5:0] c_ty_lbu   = 6'd14;
  localparam logic [5:0] c_ty_lhu   = 6'd15;
  localparam logic [5:0] c_ty_sb    = 6'd16;
  localparam logic [5:0] c_ty_sh    = 6'd17;
  localparam logic [5:0] c_ty_sw    = 6'd18;
  localparam logic [5:0] c_ty_addi  = 6'd19;
  localparam logic [5:0] c_ty_slti  = 6'd20;
  localparam logic [5:0] c_ty_sltiu = 6'd21;
  localparam logic [5:0] c_ty_xori  = 6'd22;
  localparam logic [5:0] c_ty_ori   = 6'd23;
  localparam logic [5:0] c_ty_andi  = 6'd24;
  localparam logic [5:0] c_ty_slli  = 6'd25;
  localparam logic [5:0] c_ty_srli  = 6'd26;
  localparam logic [5:0] c_ty_srai  = 6'd27;
  localparam logic [5:0] c_ty_add   = 6'd28;
  localparam logic [5:0] c_ty_sub   = 6'd29;
  localparam logic [5:0] c_ty_sll   = 6'd30;
  localparam logic [5:0] c_ty_slt   = 6'd31;
  localparam logic [5:0] c_ty_sltu  = 6'd32;
  localparam logic [5:0] c_ty_xor   = 6'd33;
  localparam logic [5:0] c_ty_srl   = 6'd34;
  localparam logic [5:0] c_ty_sra   = 6'd35;
  localparam logic [5:0] c_ty_or    = 6'd36;
  localparam logic [5:0] c_ty_and   = 6'd37;

  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  // Queue state
  logic [31:0]      inst_mem_q [QDEPTH];
  logic [31:0]      inst_mem_d [QDEPTH];
  logic [XLEN-1:0]  pc_mem_q   [QDEPTH];
  logic [XLEN-1:0]  pc_mem_d   [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ID/EX register
  logic             ex_valid_q, ex_valid_d;
  logic [5:0]       inst_type_q, inst_type_d;
  logic [XLEN-1:0]  rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]  rs2_val_q, rs2_val_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic             rd_we_q, rd_we_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             illegal_q, illegal_d;

  logic             empty;
  logic             push;
  logic             pop;
  logic             hz;
  logic             issue;

  logic [31:0]      head_inst;
  logic [XLEN-1:0]  head_pc;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       rs1_f;
  logic [4:0]       rs2_f;
  logic [4:0]       rd_f;

  logic [5:0]        dec_type;
  logic signed [31:0] dec_imm32;
  logic              dec_rs1_re;
  logic              dec_rs2_re;
  logic              dec_has_rd;
  logic              dec_ill;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_rd_we;
  logic [4:0]        dec_rd_addr;
  logic [XLEN-1:0]   op1_val;
  logic [XLEN-1:0]   op2_val;

  assign empty        = (count_q == '0);
  assign if_ready_out = (count_q != c_full_count);
  assign push         = if_valid_in && if_ready_out && !flush_in;
  assign pop          = issue;

  assign head_inst = inst_mem_q[rd_ptr_q];
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign opcode    = head_inst[6:0];
  assign funct3    = head_inst[14:12];
  assign rs1_f     = head_inst[19:15];
  assign rs2_f     = head_inst[24:20];
  assign rd_f      = head_inst[11:7];

  always_comb begin
    dec_type   = c_ty_nop;
    dec_imm32  = '0;
    dec_rs1_re = 1'b0;
    dec_rs2_re = 1'b0;
    dec_has_rd = 1'b0;
    dec_ill    = 1'b0;
    case (opcode)
      c_op_imm: begin
        dec_rs1_re = 1'b1;
        dec_has_rd = 1'b1;
        dec_imm32  = {{20{head_inst[31]}}, head_inst[31:20]};
        case (funct3)
          3'b000:  dec_type = c_ty_addi;
          3'b010:  dec_type = c_ty_slti;
          3'b011:  dec_type = c_ty_sltiu;
          3'b100:  dec_type = c_ty_xori;
          3'b110:  dec_type = c_ty_ori;
          3'b111:  dec_type = c_ty_andi;
          3'b001: begin
            dec_type  = c_ty_slli;
            dec_imm32 = {27'b0, head_inst[24:20]};
          end
          default: begin
            dec_type  = head_inst[30] ? c_ty_srai : c_ty_srli;
            dec_imm32 = {27'b0, head_inst[24:20]};
          end
        endcase
      end
      c_op_reg: begin
        dec_rs1_re = 1'b1;
        dec_rs2_re = 1'b1;
        dec_has_rd = 1'b1;
        case (funct3)
          3'b000:  dec_type = head_inst[30] ? c_ty_sub : c_ty_add;
          3'b001:  dec_type = c_ty_sll;
          3'b010:  dec_type = c_ty_slt;
          3'b011:  dec_type = c_ty_sltu;
          3'b100:  dec_type = c_ty_xor;
          3'b101:  dec_type = head_inst[30] ? c_ty_sra : c_ty_srl;
          3'b110:  dec_type = c_ty_or;
          default: dec_type = c_ty_and;
        endcase
      end
      c_op_branch: begin
        dec_rs1_re = 1'b1;
        dec_rs2_re = 1'b1;
        dec_imm32  = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                      head_inst[30:25], head_inst[11:8], 1'b0};
        case (funct3)
          3'b000:  dec_type = c_ty_beq;
          3'b001:  dec_type = c_ty_bne;
          3'b100:  dec_type = c_ty_blt;
          3'b101:  dec_type = c_ty_bge;
          3'b110:  dec_type = c_ty_bltu;
          3'b111:  dec_type = c_ty_bgeu;
          default: dec_ill  = 1'b1;
        endcase
      end
      c_op_load: begin
        dec_rs1_re = 1'b1;
        dec_has_rd = 1'b1;
        dec_imm32  = {{20{head_inst[31]}}, head_inst[31:20]};
        case (funct3)
          3'b000:  dec_type = c_ty_lb;
          3'b001:  dec_type = c_ty_lh;
          3'b010:  dec_type = c_ty_lw;
          3'b100:  dec_type = c_ty_lbu;
          3'b101:  dec_type = c_ty_lhu;
          default: dec_ill  = 1'b1;
        endcase
      end
      c_op_store: begin
        dec_rs1_re = 1'b1;
        dec_rs2_re = 1'b1;
        dec_imm32  = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
        case (funct3)
          3'b000:  dec_type = c_ty_sb;
          3'b001:  dec_type = c_ty_sh;
          3'b010:  dec_type = c_ty_sw;
          default: dec_ill  = 1'b1;
        endcase
      end
      c_op_lui: begin
        dec_has_rd = 1'b1;
        dec_type   = c_ty_lui;
        dec_imm32  = {head_inst[31:12], 12'b0};
      end
      c_op_auipc: begin
        dec_has_rd = 1'b1;
        dec_type   = c_ty_auipc;
        dec_imm32  = {head_inst[31:12], 12'b0};
      end
      c_op_jal: begin
        dec_has_rd = 1'b1;
        dec_type   = c_ty_jal;
        dec_imm32  = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                      head_inst[20], head_inst[30:21], 1'b0};
      end
      c_op_jalr: begin
        if (funct3 == 3'b000) begin
          dec_rs1_re = 1'b1;
          dec_has_rd = 1'b1;
          dec_type   = c_ty_jalr;
          dec_imm32  = {{20{head_inst[31]}}, head_inst[31:20]};
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase

    // An illegal word must not read registers or write a destination
    if (dec_ill) begin
      dec_type   = c_ty_nop;
      dec_imm32  = '0;
      dec_rs1_re = 1'b0;
      dec_rs2_re = 1'b0;
      dec_has_rd = 1'b0;
    end
  end

  assign dec_imm     = XLEN'(dec_imm32);
  assign dec_rd_we   = dec_has_rd && (rd_f != 5'd0);
  assign dec_rd_addr = dec_has_rd ? rd_f : 5'd0;

  assign rs1_read_out = dec_rs1_re && !empty;
  assign rs2_read_out = dec_rs2_re && !empty;
  assign rs1_addr_out = rs1_read_out ? rs1_f : 5'd0;
  assign rs2_addr_out = rs2_read_out ? rs2_f : 5'd0;

  // Walk sources from oldest to youngest so the lowest index wins
  always_comb begin
    op1_val = '0;
    op2_val = '0;
    if (rs1_read_out && rs1_addr_out != 5'd0) begin
      op1_val = rs1_data_in;
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_wreg_in[i] && fwd_waddr_in[5*i +: 5] == rs1_addr_out)
          op1_val = fwd_wdata_in[XLEN*i +: XLEN];
      end
    end
    if (rs2_read_out && rs2_addr_out != 5'd0) begin
      op2_val = rs2_data_in;
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_wreg_in[i] && fwd_waddr_in[5*i +: 5] == rs2_addr_out)
          op2_val = fwd_wdata_in[XLEN*i +: XLEN];
      end
    end
  end

  assign hz = !empty && ex_is_load_in && (ex_load_rd_in != 5'd0) &&
              ((rs1_read_out && rs1_addr_out == ex_load_rd_in) ||
               (rs2_read_out && rs2_addr_out == ex_load_rd_in));

  assign issue = !empty && !hz && !flush_in && (!ex_valid_q || ex_ready_in);

  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = if_inst_in;
        pc_mem_d[wr_ptr_q]   = if_pc_in;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)
        count_d = count_q + CNT_W'(1);
      else if (!push && pop)
        count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    inst_type_d = inst_type_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    imm_d       = imm_q;
    rd_we_d     = rd_we_q;
    rd_addr_d   = rd_addr_q;
    pc_d        = pc_q;
    illegal_d   = illegal_q;
    if (flush_in) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d  = 1'b1;
      inst_type_d = dec_type;
      rs1_val_d   = op1_val;
      rs2_val_d   = op2_val;
      imm_d       = dec_imm;
      rd_we_d     = dec_rd_we;
      rd_addr_d   = dec_rd_addr;
      pc_d        = head_pc;
      illegal_d   = dec_ill;
    end else if (ex_ready_in) begin
      ex_valid_d = 1'b0;
    end
  end

  // Storage carries no reset; only pointers and count define occupancy
  always_ff @(posedge clk_in) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ex_valid_q  <= 1'b0;
      inst_type_q <= c_ty_nop;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      pc_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ex_valid_q  <= ex_valid_d;
      inst_type_q <= inst_type_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      pc_q        <= pc_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid_out  = ex_valid_q;
  assign inst_type_out = inst_type_q;
  assign rs1_val_out   = rs1_val_q;
  assign rs2_val_out   = rs2_val_q;
  assign imm_out       = imm_q;
  assign rd_we_out     = rd_we_q;
  assign rd_addr_out   = rd_addr_q;
  assign pc_out        = pc_q;
  assign illegal_out   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_queue_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_id_queue_decode : directed vector table plus multi-cycle sequences.
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_id_queue_decode;

  localparam int XLEN = 32;
  localparam int QDEPTH = 4;
  localparam int NFWD = 2;
  localparam int NVEC = 14;

  logic        clk, rst;
  logic        if_valid, if_ready, flush;
  logic [31:0] if_inst, if_pc;
  logic [1:0]  fwd_wreg;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        ex_is_load;
  logic [4:0]  ex_load_rd;
  logic        rs1_read, rs2_read;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_ready, ex_valid;
  logic [5:0]  inst_type;
  logic [31:0] rs1_val, rs2_val, imm, pc_o;
  logic        rd_we, illegal;
  logic [4:0]  rd_addr;

  id_queue_decode #(.XLEN(XLEN), .QDEPTH(QDEPTH), .NFWD(NFWD)) dut (
    .clk_in(clk), .rst_in(rst),
    .if_valid_in(if_valid), .if_inst_in(if_inst), .if_pc_in(if_pc),
    .if_ready_out(if_ready), .flush_in(flush),
    .fwd_wreg_in(fwd_wreg), .fwd_waddr_in(fwd_waddr), .fwd_wdata_in(fwd_wdata),
    .ex_is_load_in(ex_is_load), .ex_load_rd_in(ex_load_rd),
    .rs1_read_out(rs1_read), .rs2_read_out(rs2_read),
    .rs1_addr_out(rs1_addr), .rs2_addr_out(rs2_addr),
    .rs1_data_in(rs1_data), .rs2_data_in(rs2_data),
    .ex_ready_in(ex_ready), .ex_valid_out(ex_valid),
    .inst_type_out(inst_type), .rs1_val_out(rs1_val), .rs2_val_out(rs2_val),
    .imm_out(imm), .rd_we_out(rd_we), .rd_addr_out(rd_addr),
    .pc_out(pc_o), .illegal_out(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  wreg;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [5:0]  ty;
    logic        re1;
    logic        re2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic        we;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs [NVEC];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    tick();
    if_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0;
    fwd_wreg = '0; fwd_waddr = '0; fwd_wdata = '0;
    ex_is_load = 1'b0; ex_load_rd = '0; rs1_data = '0; rs2_data = '0;
    ex_ready = 1'b1;

    // inst, pc, wreg, waddr{1,0}, wdata{1,0}, r1d, r2d, type, re1, re2, a1, a2, v1, v2, imm, we, rd, ill
    vecs[0]  = '{32'h00500093, 32'h40, 2'b00, 10'd0, 64'd0, 32'h99, 32'h0,
                 6'd19, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'd5, 1'b1, 5'd1, 1'b0};
    vecs[1]  = '{32'h002081B3, 32'h44, 2'b11, {5'd1, 5'd1}, {32'hBBBB, 32'hAAAA}, 32'h1111, 32'h7,
                 6'd28, 1'b1, 1'b1, 5'd1, 5'd2, 32'hAAAA, 32'h7, 32'h0, 1'b1, 5'd3, 1'b0};
    vecs[2]  = '{32'h002081B3, 32'h48, 2'b10, {5'd2, 5'd1}, {32'hBBBB, 32'hAAAA}, 32'h1111, 32'h7,
                 6'd28, 1'b1, 1'b1, 5'd1, 5'd2, 32'h1111, 32'hBBBB, 32'h0, 1'b1, 5'd3, 1'b0};
    vecs[3]  = '{32'h000001B3, 32'h4C, 2'b11, {5'd0, 5'd0}, {32'hDEAD, 32'hBEEF}, 32'h55, 32'h66,
                 6'd28, 1'b1, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0};
    vecs[4]  = '{32'hFE20CEE3, 32'h50, 2'b00, 10'd0, 64'd0, 32'd10, 32'd20,
                 6'd7, 1'b1, 1'b1, 5'd1, 5'd2, 32'd10, 32'd20, 32'hFFFFFFFC, 1'b0, 5'd0, 1'b0};
    vecs[5]  = '{32'h4030D093, 32'h54, 2'b00, 10'd0, 64'd0, 32'h80000000, 32'h5,
                 6'd27, 1'b1, 1'b0, 5'd1, 5'd0, 32'h80000000, 32'h0, 32'd3, 1'b1, 5'd1, 1'b0};
    vecs[6]  = '{32'h0000007F, 32'h58, 2'b00, 10'd0, 64'd0, 32'h12, 32'h34,
                 6'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};
    vecs[7]  = '{32'h123452B7, 32'h5C, 2'b00, 10'd0, 64'd0, 32'h33, 32'h33,
                 6'd1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h12345000, 1'b1, 5'd5, 1'b0};
    vecs[8]  = '{32'h0020A423, 32'h60, 2'b01, {5'd0, 5'd2}, {32'h0, 32'hCAFE}, 32'h1000, 32'h77,
                 6'd18, 1'b1, 1'b1, 5'd1, 5'd2, 32'h1000, 32'hCAFE, 32'd8, 1'b0, 5'd0, 1'b0};
    vecs[9]  = '{32'h010000EF, 32'h64, 2'b00, 10'd0, 64'd0, 32'h1, 32'h2,
                 6'd3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'd16, 1'b1, 5'd1, 1'b0};
    vecs[10] = '{32'h00108013, 32'h68, 2'b11, {5'd1, 5'd1}, {32'h99, 32'h42}, 32'h7, 32'h0,
                 6'd19, 1'b1, 1'b0, 5'd1, 5'd0, 32'h42, 32'h0, 32'd1, 1'b0, 5'd0, 1'b0};
    vecs[11] = '{32'h40208233, 32'h6C, 2'b00, 10'd0, 64'd0, 32'd9, 32'd4,
                 6'd29, 1'b1, 1'b1, 5'd1, 5'd2, 32'd9, 32'd4, 32'h0, 1'b1, 5'd4, 1'b0};
    vecs[12] = '{32'h00002063, 32'h70, 2'b00, 10'd0, 64'd0, 32'd9, 32'd4,
                 6'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};
    vecs[13] = '{32'hFFC12303, 32'h74, 2'b00, 10'd0, 64'd0, 32'h2000, 32'h1,
                 6'd13, 1'b1, 1'b0, 5'd2, 5'd0, 32'h2000, 32'h0, 32'hFFFFFFFC, 1'b1, 5'd6, 1'b0};

    tick();
    tick();
    chk("rst ex_valid", ex_valid, 0);
    chk("rst if_ready", if_ready, 1);
    chk("rst inst_type", inst_type, 0);
    chk("rst pc_out", pc_o, 0);
    chk("rst rd_we", rd_we, 0);
    rst = 1'b0;
    tick();
    chk("idle ex_valid", ex_valid, 0);

    for (int k = 0; k < NVEC; k++) begin
      fwd_wreg  = vecs[k].wreg;
      fwd_waddr = vecs[k].waddr;
      fwd_wdata = vecs[k].wdata;
      rs1_data  = vecs[k].r1d;
      rs2_data  = vecs[k].r2d;
      push(vecs[k].inst, vecs[k].pc);
      chk($sformatf("v%0d rs1_read", k), rs1_read, vecs[k].re1);
      chk($sformatf("v%0d rs2_read", k), rs2_read, vecs[k].re2);
      chk($sformatf("v%0d rs1_addr", k), rs1_addr, vecs[k].a1);
      chk($sformatf("v%0d rs2_addr", k), rs2_addr, vecs[k].a2);
      tick();
      chk($sformatf("v%0d ex_valid", k), ex_valid, 1);
      chk($sformatf("v%0d type", k), inst_type, vecs[k].ty);
      chk($sformatf("v%0d rs1_val", k), rs1_val, vecs[k].v1);
      chk($sformatf("v%0d rs2_val", k), rs2_val, vecs[k].v2);
      chk($sformatf("v%0d imm", k), imm, vecs[k].imm);
      chk($sformatf("v%0d rd_we", k), rd_we, vecs[k].we);
      chk($sformatf("v%0d rd_addr", k), rd_addr, vecs[k].rd);
      chk($sformatf("v%0d pc", k), pc_o, vecs[k].pc);
      chk($sformatf("v%0d illegal", k), illegal, vecs[k].ill);
    end
    fwd_wreg = '0;

    // Load-use stall on rs1 = x5
    ex_is_load = 1'b1;
    ex_load_rd = 5'd5;
    rs1_data   = 32'h500;
    push(32'h00128393, 32'h300);
    tick();
    chk("lu bubble ex_valid", ex_valid, 0);
    ex_is_load = 1'b0;
    tick();
    chk("lu issue ex_valid", ex_valid, 1);
    chk("lu issue pc", pc_o, 32'h300);
    chk("lu issue rd", rd_addr, 7);
    chk("lu issue rs1_val", rs1_val, 32'h500);
    tick();
    chk("lu drained ex_valid", ex_valid, 0);

    // Backpressure: occupy output, then fill the queue
    ex_ready = 1'b0;
    push(32'h00500093, 32'h100);
    for (int k = 0; k < 4; k++)
      push(32'h00000013 | ((32'd10 + 32'(k)) << 7), 32'(4 * k));
    chk("bp full if_ready", if_ready, 0);
    if_valid = 1'b1;
    if_inst  = 32'h00000013 | (32'd14 << 7);
    if_pc    = 32'h10;
    tick();
    if_valid = 1'b0;
    chk("bp still full", if_ready, 0);
    chk("bp hold ex_valid", ex_valid, 1);
    chk("bp hold pc", pc_o, 32'h100);
    ex_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp drain%0d ex_valid", k), ex_valid, 1);
      chk($sformatf("bp drain%0d pc", k), pc_o, 64'(4 * k));
      chk($sformatf("bp drain%0d rd", k), rd_addr, 64'(10 + k));
    end
    tick();
    chk("bp 5th dropped", ex_valid, 0);

    // Flush with two queued entries and a concurrent push
    ex_ready = 1'b0;
    push(32'h00500093, 32'h180);
    push(32'h00100113, 32'h184);
    push(32'h00200193, 32'h188);
    flush    = 1'b1;
    if_valid = 1'b1;
    if_inst  = 32'h00300213;
    if_pc    = 32'h18C;
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    chk("flush ex_valid", ex_valid, 0);
    chk("flush if_ready", if_ready, 1);
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flush empty%0d", k), ex_valid, 0);
    end

    // Asynchronous reset with three entries queued
    ex_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      push(32'h00100093, 32'h400 + 32'(4 * k));
    chk("pre-rst ex_valid", ex_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("mid-rst ex_valid", ex_valid, 0);
    chk("mid-rst if_ready", if_ready, 1);
    chk("mid-rst pc", pc_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("post-rst empty", ex_valid, 0);
    push(32'h00500093, 32'h500);
    tick();
    chk("post-rst ex_valid", ex_valid, 1);
    chk("post-rst type", inst_type, 19);
    chk("post-rst imm", imm, 5);
    chk("post-rst rd_we", rd_we, 1);
    chk("post-rst rd", rd_addr, 1);
    chk("post-rst pc", pc_o, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
